// File: rtl/key_filter_multi_if.sv
// Key filter bus: raw pins in, debounced level and event pulses out.
// slave is the filter side, master is the board/consumer side.
interface key_filter_multi_if #(
   parameter int unsigned KEY_NUM = 4
) ();

   logic [KEY_NUM-1:0] key_in;
   logic [KEY_NUM-1:0] key_state;
   logic [KEY_NUM-1:0] key_press;
   logic [KEY_NUM-1:0] key_release;
   logic [KEY_NUM-1:0] key_long;

   modport master (
      output key_in,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_state,
      output key_press,
      output key_release,
      output key_long
   );

endinterface

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per channel a 2-flop synchroniser, a both-edge
// debounce counter, and a hold counter that yields one long-press pulse per press.
module key_filter_multi #(
   parameter int unsigned KEY_NUM    = 4,
   parameter int unsigned CNT_W      = 20,
   parameter int unsigned CNT_MAX    = 999_999,
   parameter int unsigned LONG_W     = 26,
   parameter int unsigned LONG_MAX   = 49_999_999,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   key_filter_multi_if.slave       key_bus
);

   localparam logic [CNT_W-1:0]  CntMax    = CNT_W'(CNT_MAX);
   localparam logic [LONG_W-1:0] LongMax   = LONG_W'(LONG_MAX);
   localparam logic [LONG_W-1:0] LongMaxM1 = LONG_W'(LONG_MAX - 1);

   logic [KEY_NUM-1:0] state_v;
   logic [KEY_NUM-1:0] press_v;
   logic [KEY_NUM-1:0] release_v;
   logic [KEY_NUM-1:0] long_v;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
      logic              sync1_q, sync2_q;
      logic              act;
      logic              state_q, state_d;
      logic              press_q, press_d;
      logic              rel_q, rel_d;
      logic              long_q, long_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [LONG_W-1:0] hcnt_q, hcnt_d;

      // Normalise so that act = 1 means pressed regardless of pin polarity
      assign act = sync2_q ^ ACTIVE_LOW;

      // Debounce and hold-counter next state; pulses default low every cycle
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         hcnt_d  = hcnt_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         long_d  = 1'b0;

         if (act == state_q) begin
            cnt_d = '0;
         end else if (cnt_q == CntMax) begin
            state_d = act;
            cnt_d   = '0;
            press_d = act;
            rel_d   = ~act;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end

         // A release commit on the threshold edge wins over the long pulse
         if (!state_q || rel_d) begin
            hcnt_d = '0;
         end else if (hcnt_q < LongMax) begin
            hcnt_d = hcnt_q + 1'b1;
            long_d = (hcnt_q == LongMaxM1);
         end
      end

      // Channel state; synchronisers reset to the idle pin level
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
         end else begin
            sync1_q <= key_bus.key_in[i];
            sync2_q <= sync1_q;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
         end
      end

      assign state_v[i]   = state_q;
      assign press_v[i]   = press_q;
      assign release_v[i] = rel_q;
      assign long_v[i]    = long_q;
   end

   assign key_bus.key_state   = state_v;
   assign key_bus.key_press   = press_v;
   assign key_bus.key_release = release_v;
   assign key_bus.key_long    = long_v;

endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
- Multi-channel successor to the single-key debouncer: KEY_NUM independent key inputs, each synchronised, debounced on both edges, and decoded into a stable level, a press pulse, a release pulse and a long-press pulse.
- Sits between board push-buttons and the control FSMs; all outputs are registered and synchronous to sys_clk.

Parameters:
- KEY_NUM, 4, number of key channels (>=1)
- CNT_MAX, 20'd999_999, debounce window in clocks minus one (20 ms at 50 MHz); must be >=1 and < 2^CNT_W
- CNT_W, 20, debounce counter width
- LONG_MAX, 26'd49_999_999, long-press threshold in clocks after the press commit (1 s at 50 MHz); must be >=1 and < 2^LONG_W
- LONG_W, 26, hold counter width
- ACTIVE_LOW, 1, 1: key pressed = pin low; 0: key pressed = pin high

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- key_in  in  KEY_NUM  raw asynchronous key pins
- key_state  out  KEY_NUM  debounced level per channel, 1 = pressed
- key_press  out  KEY_NUM  one-clock pulse on debounced press commit
- key_release  out  KEY_NUM  one-clock pulse on debounced release commit
- key_long  out  KEY_NUM  one-clock pulse when held LONG_MAX clocks

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low. Every flop clears on its falling edge, independent of sys_clk.
- Reset values: key_state, key_press, key_release and key_long are all 0. Debounce and hold counters are 0. Synchroniser flops take the idle pin level: 1 if ACTIVE_LOW, else 0.
- Per channel: a 2-flop synchroniser produces key_sync. Normalise with act = ACTIVE_LOW ? ~key_sync : key_sync.
- Debounce counter cnt (CNT_W bits):
  - If act == key_state, cnt <= 0.
  - Else if cnt == CNT_MAX: key_state <= act, cnt <= 0, and a pulse fires on the same edge (key_press if act=1, key_release if act=0).
  - Else cnt <= cnt+1.
- Debounce result: the committed level changes only after CNT_MAX+1 consecutive clocks of disagreement. Any bounce back to the committed level restarts the count. Total pin-to-pulse latency = 2 + CNT_MAX + 1 clocks.
- Pulses are exactly one clock wide. Press and release on one channel can never coincide.
- Hold counter hcnt (LONG_W bits):
  - Cleared while key_state == 0.
  - While key_state == 1 and hcnt < LONG_MAX, it increments.
  - On the edge where hcnt == LONG_MAX-1 and key_state stays 1, key_long pulses and hcnt reaches LONG_MAX, then saturates. Result: exactly one key_long per press, LONG_MAX clocks after key_press.
- Release commit on the same edge as the long threshold: key_release fires, key_long is suppressed, hcnt clears.
- Release before the threshold: key_release only, never key_long.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Reset mid-operation (mid-count, mid-hold or during a pulse): all state clears immediately with no pulse generated. After release of reset, a pin already held pressed is treated as a new press: full debounce window, then key_press.
- Pulse outputs have no handshake. Consumers must sample them every cycle.

Test Plan (KEY_NUM=2, CNT_MAX=4, CNT_W=3, LONG_MAX=20, LONG_W=5, ACTIVE_LOW=1):
- Clean press: key_in[0] 1->0 and held -> key_press[0] high for exactly 1 clock, 7 clocks after the pin edge; key_state[0]=1 from that same cycle; channel 1 outputs stay 0.
- Bounce: key_in[0] toggles 0/1 every 2 clocks for 20 clocks, then settles at 0 -> no pulse during bouncing; key_press[0] fires 7 clocks after the final settle.
- Long press: hold key_in[0]=0 -> key_long[0] pulses once, 20 clocks after key_press[0]; no further key_long pulses while held 100 clocks; release -> key_release[0] 7 clocks after the pin rises.
- Short press: hold 10 clocks past key_press, then release -> key_release[0] only; key_long[0] never asserts; key_state[0] returns to 0.
- Simultaneous channels: both pins fall on the same edge -> key_press=2'b11 in a single cycle; release both -> key_release=2'b11.
- Reset mid-hold: assert sys_rst_n=0 at clock 10 of a hold -> all outputs 0 immediately; deassert with the pin still low -> key_press fires 7 clocks later, then key_long 20 clocks after that.
